// File: rtl/mem_arbiter.sv
// mem_arbiter: shares memory4c between I-cache fills, D-cache fills and D-cache write-throughs.
// Define ARB_RR_EN for round-robin arbitration; default build uses fixed D-over-I priority.
module mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_req,
    input  logic [ADDR_W-1:0]            i_addr,
    input  logic                         d_req,
    input  logic                         d_wr,
    input  logic [ADDR_W-1:0]            d_addr,
    input  logic [DATA_W-1:0]            d_wdata,
    output logic                         i_gnt,
    output logic                         d_gnt,
    output logic [DATA_W-1:0]            fill_data,
    output logic [$clog2(BURST_LEN)-1:0] fill_idx,
    output logic                         i_fill_vld,
    output logic                         d_fill_vld,
    output logic                         i_done,
    output logic                         d_done,
    output logic                         mem_en,
    output logic                         mem_wr,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_rvld
);
    localparam int                CNT_W    = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'((2 * BURST_LEN) - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_FILL  = 2'd1,
        D_FILL  = 2'd2,
        D_WRITE = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  issue_cnt_r;
    logic [CNT_W-1:0]  ret_cnt_r;
    logic              issue_end_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] issue_addr_s;
    logic              gnt_i_s;
    logic              gnt_d_s;
    logic              issuing_s;
    logic              rvld_ok_s;
    logic              last_ret_s;

`ifdef ARB_RR_EN
    logic last_owner_r;  // 1'b0 = I-cache, 1'b1 = D-cache

    // Round-robin: on contention grant the cache that did not win last time
    always_comb begin
        gnt_d_s = d_req & (~i_req | ~last_owner_r);
        gnt_i_s = i_req & (~d_req | last_owner_r);
    end

    // Record the winner as the grant is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner_r <= 1'b0;
        end else if ((state_r == IDLE) && gnt_d_s) begin
            last_owner_r <= 1'b1;
        end else if ((state_r == IDLE) && gnt_i_s) begin
            last_owner_r <= 1'b0;
        end else begin
            last_owner_r <= last_owner_r;
        end
    end
`else
    // Fixed priority: the D-cache wins whenever it is requesting
    always_comb begin
        gnt_d_s = d_req;
        gnt_i_s = i_req & ~d_req;
    end
`endif

    // Return words only count while a fill owns the memory; stale data is dropped
    always_comb begin
        issuing_s    = ((state_r == I_FILL) || (state_r == D_FILL)) && !issue_end_r;
        rvld_ok_s    = mem_rvld && ((state_r == I_FILL) || (state_r == D_FILL));
        last_ret_s   = rvld_ok_s && (ret_cnt_r == CNT_MAX);
        issue_addr_s = base_r | ADDR_W'({issue_cnt_r, 1'b0});
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = gnt_d_s ? (d_wr ? D_WRITE : D_FILL)
                                           : (gnt_i_s ? I_FILL : IDLE);
            I_FILL,
            D_FILL:  state_nxt_s = last_ret_s ? IDLE : state_r;
            D_WRITE: state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Burst counters and block base; counters saturate and are cleared only in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_r <= {CNT_W{1'b0}};
            issue_end_r <= 1'b0;
            ret_cnt_r   <= {CNT_W{1'b0}};
            base_r      <= {ADDR_W{1'b0}};
        end else if (state_r == IDLE) begin
            issue_cnt_r <= {CNT_W{1'b0}};
            issue_end_r <= 1'b0;
            ret_cnt_r   <= {CNT_W{1'b0}};
            base_r      <= (gnt_d_s ? d_addr : i_addr) & ~BLK_MASK;
        end else begin
            if (issuing_s) begin
                issue_cnt_r <= (issue_cnt_r == CNT_MAX) ? issue_cnt_r : issue_cnt_r + CNT_ONE;
                issue_end_r <= (issue_cnt_r == CNT_MAX);
            end
            if (rvld_ok_s && (ret_cnt_r != CNT_MAX)) begin
                ret_cnt_r <= ret_cnt_r + CNT_ONE;
            end
        end
    end

    // Output decode; return-path outputs follow mem_rvld within the same cycle
    always_comb begin
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        i_fill_vld = 1'b0;
        d_fill_vld = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = {ADDR_W{1'b0}};
        mem_wdata  = {DATA_W{1'b0}};
        fill_data  = rvld_ok_s ? mem_rdata : {DATA_W{1'b0}};
        fill_idx   = rvld_ok_s ? ret_cnt_r : {CNT_W{1'b0}};
        case (state_r)
            I_FILL: begin
                i_gnt      = 1'b1;
                mem_en     = issuing_s;
                mem_addr   = issuing_s ? issue_addr_s : {ADDR_W{1'b0}};
                i_fill_vld = rvld_ok_s;
                i_done     = last_ret_s;
            end
            D_FILL: begin
                d_gnt      = 1'b1;
                mem_en     = issuing_s;
                mem_addr   = issuing_s ? issue_addr_s : {ADDR_W{1'b0}};
                d_fill_vld = rvld_ok_s;
                d_done     = last_ret_s;
            end
            D_WRITE: begin
                d_gnt     = 1'b1;
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_done    = 1'b1;
            end
            default: begin
                i_gnt = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle pipelined memory model (data = addr ^ 0xA5A5).
// Inputs change and outputs are checked 1 ns after the falling edge.
module tb_mem_arbiter;
    logic        clk;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        i_gnt;
    logic        d_gnt;
    logic [15:0] fill_data;
    logic [2:0]  fill_idx;
    logic        i_fill_vld;
    logic        d_fill_vld;
    logic        i_done;
    logic        d_done;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rvld;
    logic        force_rvld;

    int n_chk  = 0;
    int n_pass = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_gnt(i_gnt), .d_gnt(d_gnt),
        .fill_data(fill_data), .fill_idx(fill_idx),
        .i_fill_vld(i_fill_vld), .d_fill_vld(d_fill_vld),
        .i_done(i_done), .d_done(d_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvld(mem_rvld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: a read issued in cycle c returns in cycle c+4
    logic [4:0]  pv = 5'b0;
    logic [15:0] pa [5] = '{default: 16'h0};
    always @(negedge clk) begin
        for (int s = 4; s > 0; s--) begin
            pv[s] = pv[s-1];
            pa[s] = pa[s-1];
        end
        pv[0] = mem_en & ~mem_wr;
        pa[0] = mem_addr;
    end
    assign mem_rvld  = pv[4] | force_rvld;
    assign mem_rdata = pa[4] ^ 16'hA5A5;

    function automatic logic [58:0] vec(input logic ig, dg, en, wr, input logic [15:0] a, wd,
                                        input logic iv, dv, input logic [2:0] ix,
                                        input logic [15:0] fd, input logic idn, ddn);
        return {ig, dg, en, wr, a, wd, iv, dv, ix, fd, idn, ddn};
    endfunction

    function automatic logic [58:0] obs();
        return vec(i_gnt, d_gnt, mem_en, mem_wr, mem_addr, mem_wdata,
                   i_fill_vld, d_fill_vld, fill_idx, fill_data, i_done, d_done);
    endfunction

    task automatic chk(input string tag, input logic [58:0] o, input logic [58:0] e);
        n_chk++;
        assert (o === e) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One fill starting in the next cycle; optional request drop at cycle drop_at,
    // optional reset pulse at cycle rst_at (burst abandoned there).
    task automatic txn(input logic is_d, input logic [15:0] base, input int drop_at, input int rst_at);
        logic [15:0] a;
        logic [2:0]  ix;
        logic        en;
        logic        v;
        logic        dn;
        for (int k = 0; k < 12; k++) begin
            step();
            en = (k < 8);
            a  = en ? {base[15:4], 3'(k), 1'b0} : 16'h0000;
            v  = (k >= 4);
            ix = v ? 3'(k - 4) : 3'd0;
            dn = (k == 11);
            chk(is_d ? "d_fill" : "i_fill", obs(),
                vec(!is_d, is_d, en, 1'b0, a, 16'h0000, v & !is_d, v & is_d, ix,
                    v ? ({base[15:4], ix, 1'b0} ^ 16'hA5A5) : 16'h0000, dn & !is_d, dn & is_d));
            if (k == drop_at) begin
                if (is_d) d_req = 1'b0;
                else      i_req = 1'b0;
            end
            if (k == rst_at) begin
                rst   = 1'b1;
                i_req = 1'b0;
                d_req = 1'b0;
                #1;
                chk("rst_mid_burst", obs(), 59'h0);
                #1;
                rst = 1'b0;
                return;
            end
        end
        step();
        chk("idle_gap", obs(), 59'h0);
    endtask

    initial begin
        rst        = 1'b1;
        i_req      = 1'b0;
        i_addr     = 16'h0000;
        d_req      = 1'b0;
        d_wr       = 1'b0;
        d_addr     = 16'h0000;
        d_wdata    = 16'h0000;
        force_rvld = 1'b0;

        step();
        chk("reset", obs(), 59'h0);
        rst = 1'b0;
        step();
        chk("idle", obs(), 59'h0);

        // Stray mem_rvld while idle
        force_rvld = 1'b1;
        #1;
        chk("idle_rvld", obs(), 59'h0);
        step();
        force_rvld = 1'b0;
        chk("idle_after_rvld", obs(), 59'h0);

        // Basic I fill, low address bits ignored
        i_addr = 16'h1236;
        i_req  = 1'b1;
        txn(1'b0, 16'h1236, 11, -1);

        // D write-through
        d_wr    = 1'b1;
        d_addr  = 16'h0042;
        d_wdata = 16'hBEEF;
        d_req   = 1'b1;
        step();
        chk("d_write", obs(), vec(1'b0, 1'b1, 1'b1, 1'b1, 16'h0042, 16'hBEEF,
                                  1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1));
        d_req = 1'b0;
        d_wr  = 1'b0;
        step();
        chk("after_write", obs(), 59'h0);

        // Contention: both requests raised together
        i_addr = 16'h2000;
        d_addr = 16'h3008;
        i_req  = 1'b1;
        d_req  = 1'b1;
`ifdef ARB_RR_EN
        // The write-through above left D as last owner, so I wins first, then alternation
        txn(1'b0, 16'h2000, -1, -1);
        txn(1'b1, 16'h3008, -1, -1);
        txn(1'b0, 16'h2000, 11, -1);
        txn(1'b1, 16'h3008, 11, -1);
`else
        txn(1'b1, 16'h3008, 11, -1);
        txn(1'b0, 16'h2000, 11, -1);
`endif

        // Request dropped after two issues; burst still completes
        d_addr = 16'h0100;
        d_req  = 1'b1;
        txn(1'b1, 16'h0100, 1, -1);

        // Reset at issue 5 of an I fill, stale returns must be ignored
        i_addr = 16'h4440;
        i_req  = 1'b1;
        txn(1'b0, 16'h4440, -1, 5);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("stale_rvld", obs(), 59'h0);
        end

        // New D fill served normally after the reset
        d_addr = 16'h5550;
        d_req  = 1'b1;
        txn(1'b1, 16'h5550, 11, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
